store_buffer: RTL and testbench

//   MEM-stage store buffer between the pipeline memory request and the data memory (DM) port.

---
 rtl/store_buffer_pkg.sv | 26 ++
 rtl/store_buffer_fifo.sv | 95 +++++++++
 rtl/store_buffer.sv | 103 ++++++++++
 tb/tb_store_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the MEM-stage store buffer.
//   - DM access type codes (Word/Half/Unsigned_Half/Byte/Unsigned_Byte)
//   - Default buffer depth and pointer width
//   - Word-address width used by the load/store overlap compare
package store_buffer_pkg;

  localparam logic [5:0] Word_DM          = 6'b000001;
  localparam logic [5:0] Half_DM          = 6'b000010;
  localparam logic [5:0] Unsigned_Half_DM = 6'b000100;
  localparam logic [5:0] Byte_DM          = 6'b001000;
  localparam logic [5:0] Unsigned_Byte_DM = 6'b010000;

  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = 2;

  // Overlap is decided at word granularity, so only addr[31:2] is compared.
  localparam int WADDR_W = 30;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [5:0]  dtype;
    logic [31:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Store buffer storage: circular FIFO of pending store entries.
// Ports:
//   clk, reset        clock, synchronous active-high reset (control only)
//   push_i, pop_i     enqueue at tail / dequeue head at posedge
//   in_*_i            entry fields written on push
//   head_*_o          fields of the oldest entry
//   waddr_all_o       word address (addr[31:2]) of every slot, flattened
//   valid_all_o       per-slot occupancy bit
//   count_o           number of occupied slots
//   full_o, empty_o   occupancy flags
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = SB_PTR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [31:0]              in_addr_i,
  input  logic [31:0]              in_wd_i,
  input  logic [5:0]               in_type_i,
  input  logic [31:0]              in_pc_i,
  output logic [31:0]              head_addr_o,
  output logic [31:0]              head_wd_o,
  output logic [5:0]               head_type_o,
  output logic [31:0]              head_pc_o,
  output logic [DEPTH*WADDR_W-1:0] waddr_all_o,
  output logic [DEPTH-1:0]         valid_all_o,
  output logic [PTR_W:0]           count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  sb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    vld_d = vld_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (pop_i) begin
      rd_d        = rd_q + PTR_W'(1);
      vld_d[rd_q] = 1'b0;
    end
    if (push_i) begin
      wr_d        = wr_q + PTR_W'(1);
      vld_d[wr_q] = 1'b1;
    end
    cnt_d = cnt_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  // Entry payload carries no reset; occupancy is tracked by vld_q alone.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q] <= '{addr: in_addr_i, wd: in_wd_i, dtype: in_type_i, pc: in_pc_i};
    end
  end

  always_comb begin
    waddr_all_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      waddr_all_o[i*WADDR_W +: WADDR_W] = mem_q[i].addr[31:2];
    end
  end

  assign head_addr_o = mem_q[rd_q].addr;
  assign head_wd_o   = mem_q[rd_q].wd;
  assign head_type_o = mem_q[rd_q].dtype;
  assign head_pc_o   = mem_q[rd_q].pc;
  assign valid_all_o = vld_q;
  assign count_o     = cnt_q;
  assign full_o      = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o     = (cnt_q == '0);

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer between the pipeline memory request and the DM port.
// Stores are queued and drained one per cycle when the port is free; loads go
// straight to DM and stall only on overlap with a pending store or a busy port.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/we/addr/wd/type/pc    MEM-stage request
//   flush                           kills the current request
//   dm_busy                         DM port unavailable this cycle
//   stall                           freeze pipeline F..M
//   dm_we/addr/wd/type/pc           DM port drive
//   sb_count, sb_empty              pending store count / empty flag
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = SB_PTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wd,
  input  logic [5:0]   req_type,
  input  logic [31:0]  req_pc,
  input  logic         flush,
  input  logic         dm_busy,
  output logic         stall,
  output logic         dm_we,
  output logic [31:0]  dm_addr,
  output logic [31:0]  dm_wd,
  output logic [5:0]   dm_type,
  output logic [31:0]  dm_pc,
  output logic [PTR_W:0] sb_count,
  output logic         sb_empty
);

  logic                     live, is_load, is_store;
  logic                     hit, load_stall, store_stall, load_served;
  logic                     push, pop, full, empty;
  logic [31:0]              head_addr, head_wd, head_pc;
  logic [5:0]               head_type;
  logic [DEPTH*WADDR_W-1:0] waddr_all;
  logic [DEPTH-1:0]         valid_all;

  store_buffer_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .in_addr_i   (req_addr),
    .in_wd_i     (req_wd),
    .in_type_i   (req_type),
    .in_pc_i     (req_pc),
    .head_addr_o (head_addr),
    .head_wd_o   (head_wd),
    .head_type_o (head_type),
    .head_pc_o   (head_pc),
    .waddr_all_o (waddr_all),
    .valid_all_o (valid_all),
    .count_o     (sb_count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign live     = req_valid & ~flush;
  assign is_load  = live & ~req_we;
  assign is_store = live & req_we;

  // Word-granular overlap against every occupied slot, regardless of access type.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_all[i] && (waddr_all[i*WADDR_W +: WADDR_W] == req_addr[31:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign load_stall  = is_load & (hit | dm_busy);
  // A full buffer blocks the store even if the head pops this cycle; the
  // frozen pipeline re-presents it next cycle.
  assign store_stall = is_store & full;
  assign load_served = is_load & ~load_stall;

  assign stall = ~reset & (load_stall | store_stall);
  assign push  = is_store & ~full & ~reset;
  assign pop   = ~dm_busy & ~reset & ~empty & ~load_served;

  // A served load owns the port; otherwise the head entry is presented,
  // written only when draining.
  assign dm_we   = pop;
  assign dm_addr = load_served ? req_addr : head_addr;
  assign dm_wd   = head_wd;
  assign dm_type = load_served ? req_type : head_type;
  assign dm_pc   = load_served ? req_pc   : head_pc;

  assign sb_empty = empty;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: store drain, full-buffer stall, load
// overlap stall, load port ownership, flush and reset discard.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, flush, dm_busy;
  logic [31:0] req_addr, req_wd, req_pc;
  logic [5:0]  req_type;
  logic        stall, dm_we, sb_empty;
  logic [31:0] dm_addr, dm_wd, dm_pc;
  logic [5:0]  dm_type;
  logic [2:0]  sb_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wd    (req_wd),
    .req_type  (req_type),
    .req_pc    (req_pc),
    .flush     (flush),
    .dm_busy   (dm_busy),
    .stall     (stall),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wd     (dm_wd),
    .dm_type   (dm_type),
    .dm_pc     (dm_pc),
    .sb_count  (sb_count),
    .sb_empty  (sb_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wd = '0;
    req_type = Word_DM; req_pc = '0; flush = 1'b0;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wd = d;
    req_type = Word_DM; req_pc = 32'h1000 + a; flush = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [5:0] t);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wd = '0;
    req_type = t; req_pc = 32'h2000 + a; flush = 1'b0;
  endtask

  initial begin
    idle();
    dm_busy = 1'b0;
    reset   = 1'b1;
    tick(); tick();
    check("rst_count", 32'(sb_count), 32'd0);
    check("rst_empty", 32'(sb_empty), 32'd1);
    check("rst_we",    32'(dm_we),    32'd0);
    check("rst_stall", 32'(stall),    32'd0);
    reset = 1'b0;

    // 1. single store, drains next cycle
    sw(32'h10, 32'h12345678); #1;
    check("t1_stall", 32'(stall), 32'd0);
    check("t1_nobypass_we", 32'(dm_we), 32'd0);
    tick(); idle(); #1;
    check("t1_we",    32'(dm_we),    32'd1);
    check("t1_addr",  dm_addr,       32'h10);
    check("t1_wd",    dm_wd,         32'h12345678);
    check("t1_pc",    dm_pc,         32'h1010);
    check("t1_count", 32'(sb_count), 32'd1);
    tick(); #1;
    check("t1_count0", 32'(sb_count), 32'd0);
    check("t1_we0",    32'(dm_we),    32'd0);

    // 2. fill while busy, fifth store stalls, in-order drain
    dm_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sw(32'(4*i), 32'hA0 + 32'(i)); #1;
      check("t2_fill_stall", 32'(stall), 32'd0);
      tick();
    end
    sw(32'h10, 32'hA4); #1;
    check("t2_full_stall", 32'(stall),    32'd1);
    check("t2_full_count", 32'(sb_count), 32'd4);
    check("t2_busy_we",    32'(dm_we),    32'd0);
    dm_busy = 1'b0; #1;
    check("t2_pop_stall", 32'(stall), 32'd1);
    check("t2_d0_we",     32'(dm_we), 32'd1);
    check("t2_d0_addr",   dm_addr,    32'h00);
    check("t2_d0_wd",     dm_wd,      32'hA0);
    tick();
    check("t2_retry_stall", 32'(stall), 32'd0);
    check("t2_d1_addr",     dm_addr,    32'h04);
    check("t2_d1_count",    32'(sb_count), 32'd3);
    tick(); idle(); #1;
    check("t2_d2_addr",  dm_addr,       32'h08);
    check("t2_d2_count", 32'(sb_count), 32'd3);
    tick();
    check("t2_d3_addr", dm_addr, 32'h0C);
    check("t2_d3_wd",   dm_wd,   32'hA3);
    tick();
    check("t2_d4_addr", dm_addr, 32'h10);
    check("t2_d4_wd",   dm_wd,   32'hA4);
    check("t2_d4_we",   32'(dm_we), 32'd1);
    tick();
    check("t2_empty", 32'(sb_empty), 32'd1);

    // 3. load overlapping a pending store stalls until it drains
    dm_busy = 1'b1;
    sw(32'h20, 32'h55); #1;
    tick();
    dm_busy = 1'b0;
    ld(32'h22, Half_DM); #1;
    check("t3_hit_stall", 32'(stall), 32'd1);
    check("t3_drain_we",  32'(dm_we), 32'd1);
    check("t3_drain_addr", dm_addr,   32'h20);
    tick();
    check("t3_rel_stall", 32'(stall), 32'd0);
    check("t3_ld_addr",   dm_addr,    32'h22);
    check("t3_ld_we",     32'(dm_we), 32'd0);
    check("t3_ld_type",   32'(dm_type), 32'(Half_DM));
    tick(); idle(); #1;

    // 4. non-overlapping load takes the port, drain deferred
    dm_busy = 1'b1;
    sw(32'h20, 32'h66); #1;
    tick();
    dm_busy = 1'b0;
    ld(32'h40, Word_DM); #1;
    check("t4_stall", 32'(stall),    32'd0);
    check("t4_addr",  dm_addr,       32'h40);
    check("t4_we",    32'(dm_we),    32'd0);
    check("t4_pc",    dm_pc,         32'h2040);
    check("t4_count", 32'(sb_count), 32'd1);
    tick(); idle(); #1;
    check("t4_count_kept", 32'(sb_count), 32'd1);
    check("t4_late_we",    32'(dm_we),    32'd1);
    check("t4_late_wd",    dm_wd,         32'h66);
    tick();

    // 5. flushed store neither stalls nor enqueues; flushed busy load does not stall
    sw(32'h30, 32'h77); flush = 1'b1; #1;
    check("t5_stall", 32'(stall), 32'd0);
    tick(); idle(); #1;
    check("t5_count", 32'(sb_count), 32'd0);
    check("t5_we",    32'(dm_we),    32'd0);
    dm_busy = 1'b1;
    ld(32'h30, Word_DM); flush = 1'b1; #1;
    check("t5_ld_stall", 32'(stall), 32'd0);
    idle();

    // 6. reset discards buffered stores
    for (int i = 0; i < 3; i++) begin
      sw(32'h50 + 32'(4*i), 32'hB0 + 32'(i)); #1;
      tick();
    end
    idle(); #1;
    check("t6_count3", 32'(sb_count), 32'd3);
    dm_busy = 1'b0;
    reset   = 1'b1; #1;
    check("t6_rst_we",    32'(dm_we), 32'd0);
    sw(32'h60, 32'hC0); #1;
    check("t6_rst_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b0;
    idle(); #1;
    check("t6_count",  32'(sb_count), 32'd0);
    check("t6_empty",  32'(sb_empty), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("t6_no_write", 32'(dm_we), 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
